// File: rtl/timer_evt_pkg.sv
// -----------------------------------------------------------------------------
// timer_evt_pkg
//   Shared constants for the timer event capture block: event type encodings,
//   status bit positions and the width of one stored event record
//   ({type, stamp}).
// -----------------------------------------------------------------------------
package timer_evt_pkg;

   localparam logic [1:0] EVT_MATCH = 2'b01;
   localparam logic [1:0] EVT_OVF   = 2'b10;
   localparam logic [1:0] EVT_BOTH  = 2'b11;

   localparam int ST_MATCH = 0;
   localparam int ST_OVF   = 1;
   localparam int ST_DROP  = 2;

   // One FIFO record holds the 2-bit event type above the timestamp.
   function automatic int evt_rec_width(input int timer_width);
      return timer_width + 2;
   endfunction

endpackage

// File: rtl/timer_event_capture_if.sv
// -----------------------------------------------------------------------------
// timer_event_capture_if
//   Event drain bus between the capture block and its consumer.
//   evt_pop   consumer -> capture : consume head entry
//   evt_valid capture -> consumer : head entry present
//   evt_type  capture -> consumer : head event type
//   evt_stamp capture -> consumer : head timestamp
//   evt_level capture -> consumer : FIFO occupancy
//   slave modport is used by the capture block, master by the consumer.
// -----------------------------------------------------------------------------
interface timer_event_capture_if #(
   parameter int TIMER_WIDTH = 16,
   parameter int FIFO_DEPTH  = 4
);

   logic                         evt_pop;
   logic                         evt_valid;
   logic [1:0]                   evt_type;
   logic [TIMER_WIDTH-1:0]       evt_stamp;
   logic [$clog2(FIFO_DEPTH):0]  evt_level;

   modport master (
      output evt_pop,
      input  evt_valid, evt_type, evt_stamp, evt_level
   );

   modport slave (
      input  evt_pop,
      output evt_valid, evt_type, evt_stamp, evt_level
   );

endinterface

// File: rtl/timer_evt_fifo.sv
// -----------------------------------------------------------------------------
// timer_evt_fifo
//   Synchronous first-word-fall-through FIFO. The head entry is visible on
//   dout whenever valid is high; dout reads zero while empty.
//   clk, rst_n  clock, asynchronous active-low reset (control state only)
//   push, pop   requests; pop is ignored while empty, push is ignored while
//               full unless a pop happens in the same cycle
//   din, dout   write data, head data
//   valid, full occupancy flags derived from level
//   level       number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module timer_evt_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Occupancy alone decides full/empty, so equal pointers are never ambiguous.
   assign valid   = (level != '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop & valid;
   // When full, a simultaneous pop frees the head slot that wr_ptr points at.
   assign do_push = push & (~full | do_pop);
   assign dout    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/timer_event_capture.sv
// -----------------------------------------------------------------------------
// timer_event_capture
//   Detects rising edges of the timer host's match/overflow flags, queues
//   each event with the timer_count sampled on the same edge, and raises a
//   maskable interrupt from sticky status bits.
//   clk, rst_n      clock, asynchronous active-low reset
//   timer_count     running timer value (timestamp source)
//   timer_overflow  overflow flag, rising edge = event
//   timer_match     compare-match flag, rising edge = event
//   timer_active    timer running flag (not used as a qualifier)
//   irq_mask        1 = mask status bit {drop, overflow, match}
//   irq_clear       write-one-to-clear strobes for irq_status
//   evt             event drain bus (slave side)
//   drop_count      saturating count of events lost to a full FIFO
//   irq_status      sticky {drop, overflow, match}
//   irq             registered OR of unmasked status bits
// -----------------------------------------------------------------------------
module timer_event_capture
   import timer_evt_pkg::*;
#(
   parameter int TIMER_WIDTH = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int DROP_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [TIMER_WIDTH-1:0]  timer_count,
   input  logic                    timer_overflow,
   input  logic                    timer_match,
   input  logic                    timer_active,
   input  logic [2:0]              irq_mask,
   input  logic [2:0]              irq_clear,
   timer_event_capture_if.slave    evt,
   output logic [DROP_WIDTH-1:0]   drop_count,
   output logic [2:0]              irq_status,
   output logic                    irq
);

   localparam int REC_W = evt_rec_width(TIMER_WIDTH);
   localparam int LW    = $clog2(FIFO_DEPTH) + 1;

   logic             match_p1;
   logic             ovf_p1;
   logic             rise_match;
   logic             rise_ovf;
   logic             push;
   logic             drop;
   logic             fifo_full;
   logic             fifo_valid;
   logic [1:0]       rec_type;
   logic [REC_W-1:0] rec_in;
   logic [REC_W-1:0] rec_out;
   logic [LW-1:0]    fifo_level;
   logic [2:0]       st_set;
   logic             unused_active;

   // Events are edge-only; timer_active deliberately does not gate them.
   assign unused_active = timer_active;

   function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign rise_match = timer_match & ~match_p1;
   assign rise_ovf   = timer_overflow & ~ovf_p1;
   assign push       = rise_match | rise_ovf;
   // A pop only frees space when an entry is actually present.
   assign drop       = push & fifo_full & ~(evt.evt_pop & fifo_valid);

   always_comb begin
      rec_type = EVT_MATCH;
      if (rise_match & rise_ovf) rec_type = EVT_BOTH;
      else if (rise_ovf)         rec_type = EVT_OVF;
   end

   assign rec_in = {rec_type, timer_count};

   always_comb begin
      st_set           = '0;
      st_set[ST_MATCH] = rise_match;
      st_set[ST_OVF]   = rise_ovf;
      st_set[ST_DROP]  = drop;
   end

   timer_evt_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (evt.evt_pop),
      .din   (rec_in),
      .dout  (rec_out),
      .valid (fifo_valid),
      .full  (fifo_full),
      .level (fifo_level)
   );

   assign evt.evt_valid = fifo_valid;
   assign evt.evt_type  = rec_out[REC_W-1 -: 2];
   assign evt.evt_stamp = rec_out[TIMER_WIDTH-1:0];
   assign evt.evt_level = fifo_level;

   // ---- stage p1: edge history, drop counter, sticky status, irq ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_p1   <= 1'b0;
         ovf_p1     <= 1'b0;
         drop_count <= '0;
         irq_status <= '0;
         irq        <= 1'b0;
      end else begin
         match_p1   <= timer_match;
         ovf_p1     <= timer_overflow;
         if (drop) drop_count <= sat_inc(drop_count);
         // Set wins over a coincident clear.
         irq_status <= (irq_status & ~irq_clear) | st_set;
         irq        <= |(irq_status & ~irq_mask);
      end
   end

endmodule

// File: tb/tb_timer_event_capture.sv
// -----------------------------------------------------------------------------
// tb_timer_event_capture
//   Directed bench for timer_event_capture (TIMER_WIDTH=16, FIFO_DEPTH=4,
//   DROP_WIDTH=8). A table of per-cycle vectors drives the timer flags, pop,
//   mask and clear, and lists the outputs expected just after that clock edge.
//   Hand-written sequences cover asynchronous reset and counter saturation.
// -----------------------------------------------------------------------------
module tb_timer_event_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] timer_count = '0;
   logic        timer_overflow = 1'b0;
   logic        timer_match = 1'b0;
   logic        timer_active = 1'b0;
   logic [2:0]  irq_mask = '0;
   logic [2:0]  irq_clear = '0;
   logic [7:0]  drop_count;
   logic [2:0]  irq_status;
   logic        irq;

   int errors = 0;
   int checks = 0;

   timer_event_capture_if #(.TIMER_WIDTH(16), .FIFO_DEPTH(4)) evt_bus ();

   timer_event_capture #(
      .TIMER_WIDTH (16),
      .FIFO_DEPTH  (4),
      .DROP_WIDTH  (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .timer_count    (timer_count),
      .timer_overflow (timer_overflow),
      .timer_match    (timer_match),
      .timer_active   (timer_active),
      .irq_mask       (irq_mask),
      .irq_clear      (irq_clear),
      .evt            (evt_bus),
      .drop_count     (drop_count),
      .irq_status     (irq_status),
      .irq            (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        m;
      logic        o;
      logic        act;
      logic [15:0] cnt;
      logic        pop;
      logic [2:0]  mask;
      logic [2:0]  clr;
      logic        v;
      logic [1:0]  typ;
      logic [15:0] stamp;
      logic [2:0]  lvl;
      logic [7:0]  drop;
      logic [2:0]  st;
      logic        irq;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic m, input logic o, input logic act,
                               input logic [15:0] cnt, input logic pop,
                               input logic [2:0] mask, input logic [2:0] clr,
                               input logic v, input logic [1:0] typ,
                               input logic [15:0] stamp, input logic [2:0] lvl,
                               input logic [7:0] drop, input logic [2:0] st,
                               input logic irq_e);
      vec_t t;
      t.m = m; t.o = o; t.act = act; t.cnt = cnt; t.pop = pop;
      t.mask = mask; t.clr = clr; t.v = v; t.typ = typ; t.stamp = stamp;
      t.lvl = lvl; t.drop = drop; t.st = st; t.irq = irq_e;
      tbl.push_back(t);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input logic v, input logic [1:0] typ,
                            input logic [15:0] stamp, input logic [2:0] lvl,
                            input logic [7:0] drop, input logic [2:0] st,
                            input logic irq_e);
      chk("evt_valid",  idx, 32'(evt_bus.evt_valid), 32'(v));
      chk("evt_type",   idx, 32'(evt_bus.evt_type),  32'(typ));
      chk("evt_stamp",  idx, 32'(evt_bus.evt_stamp), 32'(stamp));
      chk("evt_level",  idx, 32'(evt_bus.evt_level), 32'(lvl));
      chk("drop_count", idx, 32'(drop_count),        32'(drop));
      chk("irq_status", idx, 32'(irq_status),        32'(st));
      chk("irq",        idx, 32'(irq),               32'(irq_e));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      evt_bus.evt_pop = 1'b0;

      //   m  o  act cnt       pop mask  clr   | v  typ stamp     lvl drop st irq
      add(1, 0, 1, 16'h0042, 0, 3'd0, 3'd0,   1, 1, 16'h0042, 1, 0, 1, 0);
      add(1, 0, 1, 16'h0043, 0, 3'd0, 3'd0,   1, 1, 16'h0042, 1, 0, 1, 1);
      add(0, 0, 1, 16'h0044, 1, 3'd0, 3'd0,   0, 0, 16'h0000, 0, 0, 1, 1);
      add(0, 0, 1, 16'h0045, 0, 3'd0, 3'd1,   0, 0, 16'h0000, 0, 0, 0, 1);
      add(0, 0, 1, 16'h0046, 0, 3'd0, 3'd0,   0, 0, 16'h0000, 0, 0, 0, 0);
      add(1, 1, 1, 16'hFFFF, 0, 3'd0, 3'd0,   1, 3, 16'hFFFF, 1, 0, 3, 0);
      add(0, 0, 1, 16'h0000, 1, 3'd0, 3'd3,   0, 0, 16'h0000, 0, 0, 0, 1);
      add(0, 0, 1, 16'h0001, 0, 3'd0, 3'd0,   0, 0, 16'h0000, 0, 0, 0, 0);
      add(0, 1, 0, 16'h1234, 0, 3'd0, 3'd0,   1, 2, 16'h1234, 1, 0, 2, 0);
      add(0, 0, 0, 16'h1235, 1, 3'd0, 3'd2,   0, 0, 16'h0000, 0, 0, 0, 1);
      add(0, 0, 0, 16'h1236, 0, 3'd0, 3'd0,   0, 0, 16'h0000, 0, 0, 0, 0);
      add(1, 0, 1, 16'h0100, 0, 3'd0, 3'd0,   1, 1, 16'h0100, 1, 0, 1, 0);
      add(0, 0, 1, 16'h0101, 0, 3'd0, 3'd0,   1, 1, 16'h0100, 1, 0, 1, 1);
      add(1, 0, 1, 16'h0200, 0, 3'd0, 3'd0,   1, 1, 16'h0100, 2, 0, 1, 1);
      add(0, 0, 1, 16'h0201, 0, 3'd0, 3'd0,   1, 1, 16'h0100, 2, 0, 1, 1);
      add(1, 0, 0, 16'h0300, 0, 3'd0, 3'd0,   1, 1, 16'h0100, 3, 0, 1, 1);
      add(0, 0, 0, 16'h0301, 0, 3'd0, 3'd0,   1, 1, 16'h0100, 3, 0, 1, 1);
      add(1, 0, 1, 16'h0400, 0, 3'd0, 3'd0,   1, 1, 16'h0100, 4, 0, 1, 1);
      add(0, 0, 1, 16'h0401, 0, 3'd0, 3'd0,   1, 1, 16'h0100, 4, 0, 1, 1);
      add(1, 0, 1, 16'h0500, 0, 3'd0, 3'd0,   1, 1, 16'h0100, 4, 1, 5, 1);
      add(0, 0, 1, 16'h0501, 0, 3'd0, 3'd0,   1, 1, 16'h0100, 4, 1, 5, 1);
      add(1, 0, 1, 16'h0600, 1, 3'd0, 3'd0,   1, 1, 16'h0200, 4, 1, 5, 1);
      add(0, 0, 1, 16'h0601, 1, 3'd0, 3'd0,   1, 1, 16'h0300, 3, 1, 5, 1);
      add(0, 0, 1, 16'h0602, 1, 3'd0, 3'd0,   1, 1, 16'h0400, 2, 1, 5, 1);
      add(0, 0, 1, 16'h0603, 1, 3'd0, 3'd0,   1, 1, 16'h0600, 1, 1, 5, 1);
      add(0, 0, 1, 16'h0604, 1, 3'd0, 3'd0,   0, 0, 16'h0000, 0, 1, 5, 1);
      add(0, 0, 1, 16'h0605, 1, 3'd0, 3'd0,   0, 0, 16'h0000, 0, 1, 5, 1);
      add(0, 0, 1, 16'h0606, 0, 3'd0, 3'd7,   0, 0, 16'h0000, 0, 1, 0, 1);
      add(1, 0, 1, 16'h0700, 0, 3'd1, 3'd0,   1, 1, 16'h0700, 1, 1, 1, 0);
      add(0, 0, 1, 16'h0701, 0, 3'd1, 3'd0,   1, 1, 16'h0700, 1, 1, 1, 0);
      add(1, 0, 1, 16'h0701, 0, 3'd1, 3'd1,   1, 1, 16'h0700, 2, 1, 1, 0);
      add(0, 0, 1, 16'h0703, 0, 3'd0, 3'd0,   1, 1, 16'h0700, 2, 1, 1, 1);

      // Reset state
      #12;
      check_all(-1, 0, 0, 16'h0000, 0, 0, 0, 0);
      rst_n = 1'b1;
      step();
      check_all(-2, 0, 0, 16'h0000, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         timer_match     = tbl[i].m;
         timer_overflow  = tbl[i].o;
         timer_active    = tbl[i].act;
         timer_count     = tbl[i].cnt;
         evt_bus.evt_pop = tbl[i].pop;
         irq_mask        = tbl[i].mask;
         irq_clear       = tbl[i].clr;
         step();
         check_all(i, tbl[i].v, tbl[i].typ, tbl[i].stamp, tbl[i].lvl,
                   tbl[i].drop, tbl[i].st, tbl[i].irq);
      end

      // Third entry, then asynchronous reset in the middle of a cycle
      timer_match = 1'b1; timer_count = 16'h0702;
      evt_bus.evt_pop = 1'b0; irq_mask = '0; irq_clear = '0;
      step();
      check_all(100, 1, 1, 16'h0700, 3, 1, 1, 1);
      timer_match = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_all(101, 0, 0, 16'h0000, 0, 0, 0, 0);
      step();
      check_all(102, 0, 0, 16'h0000, 0, 0, 0, 0);
      rst_n = 1'b1;
      step();

      // Fill, then overflow the FIFO far enough to saturate drop_count
      for (int i = 0; i < 264; i++) begin
         timer_match = 1'b1; timer_count = 16'h0010 + 16'(i);
         step();
         timer_match = 1'b0;
         step();
      end
      check_all(103, 1, 1, 16'h0010, 4, 8'hFF, 5, 1);

      // Drain: stamps come back in push order
      for (int i = 0; i < 4; i++) begin
         chk("drain_stamp", i, 32'(evt_bus.evt_stamp), 32'(16'h0010 + 16'(i)));
         evt_bus.evt_pop = 1'b1;
         step();
      end
      evt_bus.evt_pop = 1'b0;
      check_all(104, 0, 0, 16'h0000, 0, 8'hFF, 5, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
